// File: rtl/rv32i_types.sv
// rv32i_types: shared cache-line constants and arbiter enums
package rv32i_types;
  localparam int LINE_BITS = 256;
  localparam int LINE_BYTES = 32;
  localparam int OFFSET_W = 5;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} arb_owner_t;
endpackage

// File: rtl/cache_arbiter_reg.sv
// cache_arbiter_reg: parameterised load-enable register with sync reset
module cache_arbiter_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbitration of icache/dcache line traffic onto one pmem port
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = LINE_BITS,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t state;
  arb_owner_t owner, last_grant, grant;
  logic op_write, dc_req;
  logic [ADDR_W-OFFSET_W-1:0] tag_q;
  logic [LINE_W-1:0] wdata_q, line_q;
  assign dc_req = dcache_read | dcache_write;
  // On contention the requester that did not win last time gets the port
  always_comb grant = (icache_read && dc_req) ? ((last_grant == DCACHE) ? ICACHE : DCACHE)
                                              : (icache_read ? ICACHE : DCACHE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= DCACHE;
      owner      <= ICACHE;
      op_write   <= 1'b0;
      tag_q      <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE) begin
      if (icache_read || dc_req) begin
        state      <= BUSY;
        owner      <= grant;
        last_grant <= grant;
        op_write   <= (grant == DCACHE) && dcache_write;
        tag_q      <= (grant == ICACHE) ? icache_address[ADDR_W-1:OFFSET_W]
                                        : dcache_address[ADDR_W-1:OFFSET_W];
        wdata_q    <= dcache_wdata;
      end
    end else if (state == BUSY) begin
      if (pmem_resp) state <= RESP;
    end else begin
      state <= IDLE;
    end
  end
  cache_arbiter_reg #(.WIDTH(LINE_W)) line_buffer (
    .clk (clk),
    .rst (rst),
    .load((state == BUSY) && pmem_resp),
    .d   (pmem_rdata),
    .q   (line_q)
  );
  assign pmem_read    = (state == BUSY) && !op_write;
  assign pmem_write   = (state == BUSY) && op_write;
  assign pmem_address = {tag_q, {OFFSET_W{1'b0}}};
  assign pmem_wdata   = wdata_q;
  assign icache_resp  = (state == RESP) && (owner == ICACHE);
  assign dcache_resp  = (state == RESP) && (owner == DCACHE);
  assign icache_rdata = line_q;
  assign dcache_rdata = line_q;
endmodule
